// File: rtl/medicine_stock_ctrl.sv
// Pill-dispenser stock controller: one saturating counter per slot, a running total,
// low-stock flags and an ASCII snapshot report streamed over a valid/ready handshake.
module medicine_stock_ctrl #(
    parameter int SLOTS      = 10,
    parameter int CNT_W      = 4,
    parameter int MAX_CNT    = 9,
    parameter int LOW_THRESH = 1,
    parameter int SUM_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SLOTS-1:0] sel_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             report_req_i,
    input  logic             tx_ready_i,
    output logic [CNT_W-1:0] sel_count_o,
    output logic             sel_valid_o,
    output logic [SUM_W-1:0] total_o,
    output logic [SLOTS-1:0] low_mask_o,
    output logic             low_alarm_o,
    output logic             sat_err_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    output logic             busy_o
);
    localparam int               IDX_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] LOW_V    = CNT_W'(LOW_THRESH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
    localparam logic [7:0]       ASCII_0  = 8'h30;
    localparam logic [7:0]       ASCII_CR = 8'h0D;
    localparam logic [7:0]       ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SEND_SLOT,
        SEND_CR,
        SEND_LF
    } state_e;

    // ---------------------------------------------------------------- selection
    logic [SLOTS-1:0] sel_q;
    logic             sel_valid_q;
    logic             sel_onehot;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        sel_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (sel_q[i]) sel_idx = IDX_W'(i);
        end
    end

    assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - SLOTS'(1))) == '0);

    // ---------------------------------------------------------------- counters
    logic [CNT_W-1:0] count_q [SLOTS];
    logic [CNT_W-1:0] count_d [SLOTS];
    logic [SUM_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] cur_cnt;
    logic             slot_hit;
    logic             reject_d, reject_q;
    logic             sat_err_q;
    logic [CNT_W-1:0] sel_count_q, sel_count_d;
    logic [SLOTS-1:0] low_mask_q, low_mask_d;
    logic             low_alarm_q;

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        count_d     = count_q;
        total_d     = total_q;
        reject_d    = 1'b0;
        cur_cnt     = count_q[sel_idx];
        slot_hit    = sel_valid_q && sel_q[sel_idx];
        sel_count_d = slot_hit ? cur_cnt : '0;

        // inc together with dec cancels out and is not treated as a tick
        if (inc_i ^ dec_i) begin
            if (!slot_hit) begin
                reject_d = 1'b1;
            end else if (inc_i) begin
                if (cur_cnt < MAX_V) begin
                    count_d[sel_idx] = cur_cnt + CNT_W'(1);
                    total_d          = total_q + SUM_W'(1);
                end else begin
                    reject_d = 1'b1;
                end
            end else begin
                if (cur_cnt != '0) begin
                    count_d[sel_idx] = cur_cnt - CNT_W'(1);
                    total_d          = total_q - SUM_W'(1);
                end else begin
                    reject_d = 1'b1;
                end
            end
        end

        for (int i = 0; i < SLOTS; i++) begin
            low_mask_d[i] = (count_q[i] <= LOW_V);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            sel_count_q <= '0;
            total_q     <= '0;
            low_mask_q  <= '1;
            low_alarm_q <= 1'b1;
            reject_q    <= 1'b0;
            sat_err_q   <= 1'b0;
            // NOTE: the counters are architectural state and must clear on reset.
            for (int i = 0; i < SLOTS; i++) count_q[i] <= '0;
        end else begin
            sel_q       <= sel_i;
            sel_valid_q <= sel_onehot;
            sel_count_q <= sel_count_d;
            total_q     <= total_d;
            low_mask_q  <= low_mask_d;
            low_alarm_q <= |low_mask_d;
            reject_q    <= reject_d;
            sat_err_q   <= reject_q;
            count_q     <= count_d;
        end
    end

    // ---------------------------------------------------------------- report FSM
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] snap_q [SLOTS];
    logic             snap_load;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             xfer;

    assign xfer = tx_valid_q && tx_ready_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        snap_load  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (report_req_i) state_d = SNAP;
            end
            SNAP: begin
                // snapshot is loaded on this edge, so the first digit comes straight from the counter
                snap_load  = 1'b1;
                idx_d      = '0;
                state_d    = SEND_SLOT;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
                tx_data_d  = ASCII_0 + 8'(count_q[0]);
            end
            SEND_SLOT: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = SEND_CR;
                        tx_data_d = ASCII_CR;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = ASCII_0 + 8'(snap_q[idx_d]);
                    end
                end
            end
            SEND_CR: begin
                if (xfer) begin
                    state_d   = SEND_LF;
                    tx_data_d = ASCII_LF;
                end
            end
            SEND_LF: begin
                if (xfer) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Snapshot is always written in SNAP before any byte reads it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (snap_load) snap_q <= count_q;
    end

    assign sel_count_o = sel_count_q;
    assign sel_valid_o = sel_valid_q;
    assign total_o     = total_q;
    assign low_mask_o  = low_mask_q;
    assign low_alarm_o = low_alarm_q;
    assign sat_err_o   = sat_err_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_medicine_stock_ctrl.sv
// Self-checking bench for medicine_stock_ctrl: a behavioural stock/report model compared
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_medicine_stock_ctrl;
    localparam int SLOTS      = 10;
    localparam int CNT_W      = 4;
    localparam int MAX_CNT    = 9;
    localparam int LOW_THRESH = 1;
    localparam int SUM_W      = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SLOTS-1:0] sel = '0;
    logic             inc = 1'b0;
    logic             dec = 1'b0;
    logic             report_req = 1'b0;
    logic             tx_ready = 1'b0;
    logic [CNT_W-1:0] sel_count;
    logic             sel_valid;
    logic [SUM_W-1:0] total;
    logic [SLOTS-1:0] low_mask;
    logic             low_alarm;
    logic             sat_err;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;

    always #5 clk = ~clk;

    medicine_stock_ctrl #(
        .SLOTS(SLOTS), .CNT_W(CNT_W), .MAX_CNT(MAX_CNT), .LOW_THRESH(LOW_THRESH), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .sel_i(sel), .inc_i(inc), .dec_i(dec),
        .report_req_i(report_req), .tx_ready_i(tx_ready),
        .sel_count_o(sel_count), .sel_valid_o(sel_valid), .total_o(total),
        .low_mask_o(low_mask), .low_alarm_o(low_alarm), .sat_err_o(sat_err),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .busy_o(busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int               m_cnt [SLOTS];
    logic [SLOTS-1:0] m_selq;
    bit               m_sv;
    int               m_sel_count;
    logic [SLOTS-1:0] m_low;
    bit               m_rej_pend;
    bit               m_sat;
    int               m_rep;        // 0 idle, 1 snapshot pending, 2 sending
    logic [7:0]       m_q[$];

    function automatic int lowest_bit(input logic [SLOTS-1:0] v);
        for (int i = 0; i < SLOTS; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_selq = '0; m_sv = 0; m_sel_count = 0; m_low = '1;
        m_rej_pend = 0; m_sat = 0; m_rep = 0; m_q.delete();
    endtask

    task automatic model_step();
        int slot;
        bit ok, rej;
        logic [SLOTS-1:0] lm;
        slot = lowest_bit(m_selq);
        ok   = m_sv && (slot >= 0);
        m_sel_count = ok ? m_cnt[slot] : 0;
        for (int i = 0; i < SLOTS; i++) lm[i] = (m_cnt[i] <= LOW_THRESH);
        m_sat = m_rej_pend;
        case (m_rep)
            0: if (report_req) m_rep = 1;
            1: begin
                m_q.delete();
                for (int i = 0; i < SLOTS; i++) m_q.push_back(8'(48 + m_cnt[i]));
                m_q.push_back(8'h0D);
                m_q.push_back(8'h0A);
                m_rep = 2;
            end
            default: if (tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_rep = 0;
            end
        endcase
        rej = 0;
        if (inc != dec) begin
            if (!ok) rej = 1;
            else if (inc) begin
                if (m_cnt[slot] < MAX_CNT) m_cnt[slot]++; else rej = 1;
            end else begin
                if (m_cnt[slot] > 0) m_cnt[slot]--; else rej = 1;
            end
        end
        m_rej_pend = rej;
        m_low  = lm;
        m_sv   = ($countones(m_selq) == 1);
        m_selq = sel;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------------------------------------------------------- compare
    logic [7:0] dut_bytes[$];
    int         sat_seen = 0;
    bit         prev_valid = 0;
    logic [7:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
            end else begin
                check("sel_count", sel_count, m_sel_count);
                check("sel_valid", sel_valid, m_sv);
                check("total", total, m_cnt.sum());
                check("low_mask", low_mask, m_low);
                check("low_alarm", low_alarm, |m_low);
                check("sat_err", sat_err, m_sat);
                check("tx_valid", tx_valid, m_rep == 2);
                check("busy", busy, m_rep == 2);
                if (m_rep == 2 && m_q.size() > 0) check("tx_data", tx_data, m_q[0]);
                if (prev_valid && !tx_ready) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
                if (prev_valid && tx_ready) dut_bytes.push_back(prev_data);
                if (sat_err) sat_seen++;
                prev_valid = tx_valid;
                prev_data  = tx_data;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_report(input string tag);
        logic [7:0] exp_b;
        check({tag, "_len"}, dut_bytes.size(), 12);
        for (int i = 0; i < 12; i++) begin
            exp_b = (i == 0) ? 8'h33 : (i == 1) ? 8'h39 : (i == 10) ? 8'h0D : (i == 11) ? 8'h0A : 8'h30;
            if (i < dut_bytes.size()) check($sformatf("%s_byte%0d", tag, i), dut_bytes[i], exp_b);
            else check($sformatf("%s_byte%0d", tag, i), 32'hFFFF_FFFF, exp_b);
        end
    endtask

    task automatic wait_idle(input string tag);
        cyc(2);
        for (int i = 0; i < 80 && busy; i++) cyc(1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    int s0;

    initial begin
        cyc(2);
        check("rst_total", total, 0);
        check("rst_low_mask", low_mask, 10'h3FF);
        check("rst_low_alarm", low_alarm, 1);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        cyc(2);

        // slot 0 up to 3
        sel = 10'h001; cyc(3);
        inc = 1; cyc(3); inc = 0; cyc(3);
        check("t1_sel_count", sel_count, 3);
        check("t1_total", total, 3);
        check("t1_low_mask", low_mask, 10'h3FE);
        check("t1_low_alarm", low_alarm, 1);

        // slot 2 saturates at 9, then drains past 0
        sel = 10'h004; cyc(3);
        s0 = sat_seen; inc = 1; cyc(10); inc = 0; cyc(3);
        check("t2_sel_count_max", sel_count, 9);
        check("t2_total_max", total, 12);
        check("t2_sat_inc", sat_seen - s0, 1);
        s0 = sat_seen; dec = 1; cyc(10); dec = 0; cyc(3);
        check("t2_sel_count_min", sel_count, 0);
        check("t2_total_min", total, 3);
        check("t2_sat_dec", sat_seen - s0, 1);

        // invalid selection, then inc+dec together on slot 1
        sel = 10'h003; cyc(3);
        s0 = sat_seen; inc = 1; cyc(1); inc = 0; cyc(3);
        check("t3_sel_valid", sel_valid, 0);
        check("t3_total", total, 3);
        check("t3_sat_invalid", sat_seen - s0, 1);
        sel = 10'h002; cyc(3);
        s0 = sat_seen; inc = 1; dec = 1; cyc(1); inc = 0; dec = 0; cyc(3);
        check("t3_both_count", sel_count, 0);
        check("t3_both_sat", sat_seen - s0, 0);
        inc = 1; cyc(9); inc = 0; cyc(3);
        check("t3_slot1", sel_count, 9);
        check("t3_low_mask", low_mask, 10'h3FC);

        // report with tx_ready held high
        tx_ready = 1; dut_bytes.delete();
        report_req = 1; cyc(1); report_req = 0;
        wait_idle("t4");
        check_report("t4");

        // report with tx_ready toggling, inc on slot 0 mid-report
        sel = 10'h001; tx_ready = 0; cyc(3);
        dut_bytes.delete();
        report_req = 1; cyc(1); report_req = 0;
        for (int i = 0; i < 80; i++) begin
            tx_ready = i[0];
            inc = (i == 6);
            cyc(1);
            if (i > 3 && !busy) break;
        end
        inc = 0; tx_ready = 0;
        check("t5_busy_end", busy, 0);
        check_report("t5");
        cyc(2);
        check("t5_total", total, 13);
        check("t5_sel_count", sel_count, 4);

        // reset during the 4th report byte
        report_req = 1; cyc(1); report_req = 0;
        cyc(2);
        tx_ready = 1; cyc(3); tx_ready = 0; cyc(1);
        check("t6_4th_valid", tx_valid, 1);
        check("t6_4th_byte", tx_data, 8'h30);
        rst = 1; cyc(1); rst = 0; cyc(1);
        check("t6_tx_valid", tx_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_total", total, 0);
        check("t6_low_alarm", low_alarm, 1);
        check("t6_low_mask", low_mask, 10'h3FF);
        check("t6_sel_count", sel_count, 0);
        cyc(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
